// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: valid/ready pipeline stage with a stall-cycle counter.
// SKID=1 builds a two-entry skid buffer whose in_ready is a pure function of
// registered state; SKID=0 builds a single register whose in_ready is
// combinational in out_ready.
module pipe_stage_buf #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned SKID   = 1,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic [DATA_W-1:0]   skid_q, skid_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                acc;
    logic                rel;

    assign acc       = in_valid & in_ready;
    assign rel       = out_valid & out_ready;
    assign out_data  = out_data_q;
    assign stall_cnt = cnt_q;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus the matching output/skid data moves; flush wins over any handshake.
    always_comb begin
        state_d    = state_q;
        out_data_d = out_data_q;
        skid_d     = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (acc) begin
                        state_d    = ST_ONE;
                        out_data_d = in_data;
                    end
                end
                ST_ONE: begin
                    if (acc && rel) begin
                        out_data_d = in_data;
                    end else if (acc) begin
                        // Only reachable with SKID=1; SKID=0 never accepts while stalled.
                        state_d = ST_FULL;
                        skid_d  = in_data;
                    end else if (rel) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (rel) begin
                        state_d    = ST_ONE;
                        out_data_d = skid_q;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    // Handshake outputs decoded from state (and out_ready only in single-register mode).
    always_comb begin
        out_valid = (state_q != ST_EMPTY);
        if (SKID != 0) begin
            in_ready = (state_q != ST_FULL);
        end else begin
            in_ready = out_ready | ~out_valid;
        end
    end

    // Saturating stall counter; clear beats increment, flush does not touch it.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (out_valid && !out_ready && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Datapath and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_q <= '0;
            skid_q     <= '0;
            cnt_q      <= '0;
        end else begin
            out_data_q <= out_data_d;
            skid_q     <= skid_d;
            cnt_q      <= cnt_d;
        end
    end

endmodule

// File: doc/pipe_stage_buf.md
PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

Interface
REQ-001 SHALL have parameter DATA_W, default 32, payload width in bits (minimum 1).
REQ-002 SHALL have parameter SKID, default 1, where 1 selects a two-entry skid buffer and 0 selects a single register.
REQ-003 SHALL have parameter CNT_W, default 8, stall counter width (minimum 1).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port flush, input, 1 bit: synchronous discard of all held entries.
REQ-007 SHALL have port in_valid, input, 1 bit: upstream offers in_data.
REQ-008 SHALL have port in_ready, output, 1 bit: the block can accept this cycle.
REQ-009 SHALL have port in_data, input, DATA_W bits: upstream payload.
REQ-010 SHALL have port out_valid, output, 1 bit: out_data holds an entry.
REQ-011 SHALL have port out_ready, input, 1 bit: downstream accepts this cycle.
REQ-012 SHALL have port out_data, output, DATA_W bits: oldest held entry.
REQ-013 SHALL have port cnt_clr, input, 1 bit: synchronous clear of stall_cnt.
REQ-014 SHALL have port stall_cnt, output, CNT_W bits: count of cycles with out_valid=1 and out_ready=0.

Function
REQ-015 SHALL accept an entry when in_valid and in_ready are both 1 at a clock edge, and release one when out_valid and out_ready are both 1.
REQ-016 SHALL deliver entries in strict FIFO order with no loss or duplication outside flush.
REQ-017 SHALL give 1-cycle latency: an entry accepted into an empty block appears on out_data with out_valid=1 the following cycle.
REQ-018 SHALL, with SKID=1, run states EMPTY, ONE and FULL, with in_ready=1 exactly when the state is not FULL, driven from a flop with no combinational path from out_ready.
REQ-019 SHALL, with SKID=1, make these transitions: EMPTY to ONE on accept; ONE to FULL on accept without release; ONE to EMPTY on release without accept; ONE stays ONE on simultaneous accept and release; FULL to ONE on release, with the skid entry moving to the output register in the same cycle.
REQ-020 SHALL, with SKID=1, sustain one transfer per cycle whenever in_valid and out_ready are held at 1.
REQ-021 SHALL, with SKID=0, drive in_ready = out_ready OR NOT out_valid combinationally, and hold one entry at most.
REQ-022 SHALL, while out_valid=1 and out_ready=0, hold out_data and out_valid stable.
REQ-023 SHALL, on flush=1, set the state to EMPTY and out_valid=0 at the next edge, with any simultaneous accept or release ignored so the input is dropped.
REQ-024 SHALL keep in_ready unchanged by flush within the same cycle; it reflects state only.
REQ-025 SHALL, while out_valid=0, hold out_data at its last value, and consumers SHALL ignore out_data while out_valid=0.
REQ-026 SHALL increment stall_cnt each cycle that out_valid=1 and out_ready=0, saturating at 2^CNT_W-1 without wrapping.
REQ-027 SHALL give cnt_clr priority over increment, so the next value is 0.
REQ-028 SHALL leave stall_cnt unaffected by flush.

Reset
REQ-029 SHALL, on rst=1 and regardless of clk, force the state to EMPTY, out_valid=0, out_data=0, the skid data to 0 and stall_cnt=0.
REQ-030 SHALL drive in_ready=1 during and after reset in both SKID modes.
REQ-031 SHALL discard any entry in flight on reset mid-transfer, with no entry emerging after rst falls.
REQ-032 SHALL accept on the first rising edge after rst deasserts.

Verification
REQ-033 SHALL be verified by a fill/drain scenario: SKID=1, out_ready=0, push 0xA1, 0xA2 -> in_ready=0 after the second edge; out_data=0xA1; then out_ready=1 -> 0xA1 then 0xA2 out on consecutive cycles, in_ready=1 the cycle after the first release.
REQ-034 SHALL be verified by a streaming scenario: in_valid=1 and out_ready=1 for 10 cycles with data 1..10 -> out_data 1..10 on consecutive cycles starting 1 cycle after the first push, in_ready constantly 1.
REQ-035 SHALL be verified by a flush scenario: state FULL (0x11, 0x22) with flush=1 and in_valid=1 (0x33) in the same cycle -> next cycle out_valid=0, in_ready=1; 0x33 never emerges.
REQ-036 SHALL be verified by a saturation scenario: CNT_W=3, out_valid=1 with out_ready=0 for 10 cycles -> stall_cnt reads 1..7 then holds 7; cnt_clr=1 for one cycle -> 0.
REQ-037 SHALL be verified by an async reset scenario: rst pulsed mid-cycle while FULL -> out_valid=0, out_data=0 and stall_cnt=0 immediately, before the next clk edge.
REQ-038 SHALL be verified by a SKID=0 scenario: out_valid=1 with out_ready toggled 0/1 -> in_ready follows out_ready combinationally; an entry pushed while out_ready=1 replaces the released one in the same edge.
